// File: rtl/cuckoo_lookup_fsm.sv
// cuckoo_lookup_fsm
//   Four-way cuckoo hash table lookup sequencer. A request VPN is latched, then
//   each way is probed in order (PROBE drives the bucket read, CHECK compares
//   the returned entry). The first matching way ends the walk, so the
//   lowest-numbered hit wins. If all four ways miss, a miss is reported.
//   The result is held in RESP until the consumer takes it.
//
//   Ports
//     clock, reset_n                  clock, async active-low reset
//     req_valid/req_ready, req_vpn    lookup request (ready only when idle)
//     hash_vpn, hash_id               operands to the external combinational hash
//     hash_in                         hash result, same cycle as hash_vpn/hash_id
//     mem_rd_en, mem_rd_addr          bucket read, addr = {way, hash_in[IDX_BITS-1:0]}
//     mem_rd_vld/tag/ppn              bucket entry, one cycle after mem_rd_en
//     rsp_valid/rsp_ready             response handshake
//     rsp_hit, rsp_way, rsp_ppn       result (miss reports way 3, ppn 0)
//     stat_hits, stat_misses          saturating 32-bit counters, present only
//                                     when CUCKOO_LOOKUP_STATS_EN is defined
module cuckoo_lookup_fsm #(
  parameter int IDX_BITS = 10,
  parameter int PPN_BITS = 40
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [44:0]           req_vpn,
  output logic [44:0]           hash_vpn,
  output logic [1:0]            hash_id,
  input  logic [31:0]           hash_in,
  output logic                  mem_rd_en,
  output logic [IDX_BITS+1:0]   mem_rd_addr,
  input  logic                  mem_rd_vld,
  input  logic [44:0]           mem_rd_tag,
  input  logic [PPN_BITS-1:0]   mem_rd_ppn,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_hit,
  output logic [1:0]            rsp_way,
  output logic [PPN_BITS-1:0]   rsp_ppn
`ifdef CUCKOO_LOOKUP_STATS_EN
  ,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses
`endif
);

  typedef enum logic [1:0] {IDLE, PROBE, CHECK, RESP} state_t;

  state_t      state;
  logic [1:0]  way;
  logic [44:0] vpn;
  logic        tag_hit;

  // Only the low IDX_BITS of the hash select a bucket.
  logic unused_hash;
  assign unused_hash = ^hash_in[31:IDX_BITS];

  assign hash_vpn    = vpn;
  assign hash_id     = way;
  assign mem_rd_addr = {way, hash_in[IDX_BITS-1:0]};

  // Returned entry is only meaningful in CHECK (one cycle after PROBE's read).
  assign tag_hit = mem_rd_vld && (mem_rd_tag == vpn);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      way       <= '0;
      vpn       <= '0;
      req_ready <= 1'b1;
      mem_rd_en <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_way   <= '0;
      rsp_ppn   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            vpn       <= req_vpn;
            way       <= '0;
            req_ready <= 1'b0;
            mem_rd_en <= 1'b1;
            state     <= PROBE;
          end
        end
        PROBE: begin
          mem_rd_en <= 1'b0;
          state     <= CHECK;
        end
        CHECK: begin
          if (tag_hit) begin
            rsp_hit   <= 1'b1;
            rsp_way   <= way;
            rsp_ppn   <= mem_rd_ppn;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (way == 2'd3) begin
            rsp_hit   <= 1'b0;
            rsp_way   <= 2'd3;
            rsp_ppn   <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            way       <= way + 2'd1;
            mem_rd_en <= 1'b1;
            state     <= PROBE;
          end
        end
        RESP: begin
          // rsp_* hold their values until taken; IDLE re-opens req_ready.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CUCKOO_LOOKUP_STATS_EN
  // Counted on the cycle the FSM moves CHECK -> RESP.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state == CHECK) begin
      if (tag_hit && stat_hits != 32'hFFFF_FFFF)
        stat_hits <= stat_hits + 32'd1;
      if (!tag_hit && way == 2'd3 && stat_misses != 32'hFFFF_FFFF)
        stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cuckoo_lookup_fsm.sv
module tb_cuckoo_lookup_fsm;
  localparam int IDX_BITS = 10;
  localparam int PPN_BITS = 40;

  logic                clock = 1'b0;
  logic                reset_n;
  logic                req_valid;
  logic                req_ready;
  logic [44:0]         req_vpn;
  logic [44:0]         hash_vpn;
  logic [1:0]          hash_id;
  logic [31:0]         hash_in;
  logic                mem_rd_en;
  logic [IDX_BITS+1:0] mem_rd_addr;
  logic                mem_rd_vld;
  logic [44:0]         mem_rd_tag;
  logic [PPN_BITS-1:0] mem_rd_ppn;
  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_hit;
  logic [1:0]          rsp_way;
  logic [PPN_BITS-1:0] rsp_ppn;

  int nassert = 0;
  int nfail   = 0;

  // Table model: one flat array indexed by {way, bucket}.
  logic                tvld [4096];
  logic [44:0]         ttag [4096];
  logic [PPN_BITS-1:0] tppn [4096];

  logic [1:0]          rd_ids   [$];
  logic [IDX_BITS+1:0] rd_addrs [$];

  cuckoo_lookup_fsm #(.IDX_BITS(IDX_BITS), .PPN_BITS(PPN_BITS)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_vpn(req_vpn),
    .hash_vpn(hash_vpn), .hash_id(hash_id), .hash_in(hash_in),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_vld(mem_rd_vld), .mem_rd_tag(mem_rd_tag), .mem_rd_ppn(mem_rd_ppn),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hit(rsp_hit), .rsp_way(rsp_way), .rsp_ppn(rsp_ppn)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] hfn(input logic [44:0] v, input logic [1:0] id);
    logic [31:0] x;
    x = v[31:0] ^ {19'd0, v[44:32]} ^ {id, 30'd0};
    return (x * (32'h9E37_79B1 + {30'd0, id} * 32'h0101_0101)) ^ (x >> 13);
  endfunction

  assign hash_in = hfn(hash_vpn, hash_id);

  function automatic logic [IDX_BITS+1:0] addr_of(input logic [44:0] v, input logic [1:0] w);
    logic [31:0] h;
    h = hfn(v, w);
    return {w, h[IDX_BITS-1:0]};
  endfunction

  // Bucket memory: one-cycle read latency, garbage when not reading.
  always @(posedge clock) begin
    if (mem_rd_en) begin
      rd_ids.push_back(hash_id);
      rd_addrs.push_back(mem_rd_addr);
      mem_rd_vld <= tvld[mem_rd_addr];
      mem_rd_tag <= ttag[mem_rd_addr];
      mem_rd_ppn <= tppn[mem_rd_addr];
    end else begin
      mem_rd_vld <= 1'($urandom);
      mem_rd_tag <= {13'($urandom), $urandom};
      mem_rd_ppn <= {8'($urandom), $urandom};
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nassert++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < 4096; i++) begin
      tvld[i] = 1'b0; ttag[i] = '0; tppn[i] = '0;
    end
  endtask

  task automatic set_entry(input logic [44:0] v, input logic [1:0] w, input logic vld,
                           input logic [44:0] tag, input logic [PPN_BITS-1:0] ppn);
    logic [IDX_BITS+1:0] a;
    a = addr_of(v, w);
    tvld[a] = vld; ttag[a] = tag; tppn[a] = ppn;
  endtask

  // First way in ascending order whose entry is valid with an exact tag wins.
  task automatic model(input logic [44:0] v, output bit h, output logic [1:0] w,
                       output logic [PPN_BITS-1:0] p);
    logic [IDX_BITS+1:0] a;
    h = 0; w = 2'd3; p = '0;
    for (int k = 0; k < 4; k++) begin
      a = addr_of(v, 2'(k));
      if (!h && tvld[a] && ttag[a] == v) begin
        h = 1; w = 2'(k); p = tppn[a];
      end
    end
  endtask

  // Issue one lookup, check result/latency/probe sequence, hold rsp_ready low
  // for 'hold' cycles, then complete the handshake.
  task automatic do_lookup(input logic [44:0] v, input int hold);
    int lat, nrd;
    bit eh;
    logic [1:0] ew;
    logic [PPN_BITS-1:0] ep;
    logic [IDX_BITS+1:0] ea;
    logic [1:0] wi;
    model(v, eh, ew, ep);
    nrd = eh ? int'(ew) + 1 : 4;
    chk("req_ready_idle", req_ready, 1);
    rd_ids.delete(); rd_addrs.delete();
    req_valid = 1'b1; req_vpn = v;
    @(posedge clock); #1;
    req_valid = 1'b0; req_vpn = {13'($urandom), $urandom};
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clock); #1; lat++;
    end
    chk("latency", lat, eh ? 2 * (int'(ew) + 1) + 1 : 9);
    chk("rsp_hit", rsp_hit, eh);
    chk("rsp_way", rsp_way, ew);
    chk("rsp_ppn", rsp_ppn, ep);
    chk("hash_vpn", hash_vpn, v);
    chk("rd_count", rd_ids.size(), nrd);
    for (int i = 0; i < rd_ids.size() && i < 4; i++) begin
      wi = 2'(i);
      ea = addr_of(v, wi);
      chk("rd_id", rd_ids[i], wi);
      chk("rd_addr", rd_addrs[i], ea);
    end
    for (int c = 0; c < hold; c++) begin
      @(posedge clock); #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_hit", rsp_hit, eh);
      chk("hold_way", rsp_way, ew);
      chk("hold_ppn", rsp_ppn, ep);
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_req_ready", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [44:0] vpn, v2;
    logic [63:0] r;
    bit found, seen;
    clear_table();
    reset_n = 1'b0; req_valid = 1'b0; req_vpn = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_hit", rsp_hit, 0);
    chk("rst_rsp_way", rsp_way, 0);
    chk("rst_rsp_ppn", rsp_ppn, 0);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_hash_vpn", hash_vpn, 0);
    chk("rst_hash_id", hash_id, 0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    chk("rst_req_ready", req_ready, 1);

    vpn = 45'h0_1234_5678_9AB;

    // Hit in way 0, consumer stalls 5 cycles.
    set_entry(vpn, 2'd0, 1'b1, vpn, 40'hAB_CDEF_0123);
    do_lookup(vpn, 5);

    // Ways 0/1 tag mismatch, way 2 hits.
    clear_table();
    set_entry(vpn, 2'd0, 1'b1, vpn ^ 45'd1, 40'h11);
    set_entry(vpn, 2'd1, 1'b1, vpn ^ 45'h100, 40'h22);
    set_entry(vpn, 2'd2, 1'b1, vpn, 40'h33_4455_6677);
    do_lookup(vpn, 0);

    // All miss; way 1 has matching tag but is invalid.
    clear_table();
    set_entry(vpn, 2'd0, 1'b1, vpn ^ 45'h8, 40'h1);
    set_entry(vpn, 2'd1, 1'b0, vpn, 40'hDEAD);
    set_entry(vpn, 2'd2, 1'b1, ~vpn, 40'h2);
    set_entry(vpn, 2'd3, 1'b1, vpn ^ 45'h1_0000_0000_000, 40'h3);
    do_lookup(vpn, 2);

    // Ways 1 and 3 both match: way 1 reported, way 3 never read.
    clear_table();
    set_entry(vpn, 2'd1, 1'b1, vpn, 40'h0F_0000_0001);
    set_entry(vpn, 2'd3, 1'b1, vpn, 40'h0F_0000_0003);
    do_lookup(vpn, 1);

    // Reset during the way-2 probe abandons the lookup.
    clear_table();
    set_entry(vpn, 2'd2, 1'b1, vpn, 40'h77);
    req_valid = 1'b1; req_vpn = vpn;
    @(posedge clock); #1; req_valid = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (mem_rd_en && hash_id == 2'd2) found = 1;
      else begin @(posedge clock); #1; end
    end
    chk("reach_probe_way2", found, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_mem_rd_en", mem_rd_en, 0);
    chk("midrst_hash_id", hash_id, 0);
    @(negedge clock); reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clock); #1;
      if (rsp_valid) seen = 1;
    end
    chk("midrst_no_rsp", seen, 0);
    chk("midrst_req_ready", req_ready, 1);
    do_lookup(vpn, 0);

    // Randomized lookups against the table model.
    for (int n = 0; n < 40; n++) begin
      r = {$urandom, $urandom};
      v2 = r[44:0];
      for (int w = 0; w < 4; w++) begin
        r = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0: set_entry(v2, 2'(w), 1'b1, v2, r[PPN_BITS-1:0]);
          1: set_entry(v2, 2'(w), 1'b0, v2, r[PPN_BITS-1:0]);
          2: set_entry(v2, 2'(w), 1'b1, v2 ^ (45'd1 << $urandom_range(0, 44)), r[PPN_BITS-1:0]);
          default: ;
        endcase
      end
      do_lookup(v2, $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule

// File: doc/cuckoo_lookup_fsm.md
CUCKOO_LOOKUP_FSM -- requirements
Module: cuckoo_lookup_fsm

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter IDX_BITS, default 10: bucket index width, taken from hash_in[IDX_BITS-1:0].
REQ-003 Parameter PPN_BITS, default 40: physical page number width.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 req_valid / req_ready  in / out  1 / 1  lookup request handshake.
REQ-007 req_vpn  in  45  virtual page number to look up.
REQ-008 hash_vpn / hash_id  out  45 / 2  operands driven to the combinational tabulation hash stage.
REQ-009 hash_in  in  32  hash result, valid in the same cycle as hash_vpn/hash_id.
REQ-010 mem_rd_en / mem_rd_addr  out  1 / IDX_BITS+2  bucket read strobe; address = {hash_id, hash_in[IDX_BITS-1:0]}.
REQ-011 mem_rd_vld / mem_rd_tag / mem_rd_ppn  in  1 / 45 / PPN_BITS  bucket entry, returned exactly one cycle after mem_rd_en.
REQ-012 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-013 rsp_hit / rsp_way / rsp_ppn  out  1 / 2 / PPN_BITS  result fields.

Function
REQ-014 FSM states SHALL be IDLE, PROBE, CHECK, RESP; the way counter SHALL be 2 bits.
REQ-015 req_ready SHALL be 1 only in IDLE; on req_valid&req_ready the VPN is latched, way counter cleared, next state PROBE.
REQ-016 hash_vpn SHALL always be the latched VPN; hash_id SHALL equal the way counter.
REQ-017 PROBE SHALL last one cycle, assert mem_rd_en, and go to CHECK; mem_rd_en SHALL be 0 in all other states.
REQ-018 In CHECK, a hit is mem_rd_vld=1 and mem_rd_tag equals the full 45-bit latched VPN.
REQ-019 On hit: latch rsp_hit=1, rsp_way=way, rsp_ppn=mem_rd_ppn; go to RESP; remaining ways are not probed, so the lowest-numbered matching way wins.
REQ-020 On miss with way<3: increment way and return to PROBE.
REQ-021 On miss with way=3: latch rsp_hit=0, rsp_way=3, rsp_ppn=0; go to RESP.
REQ-022 Latency from the accept edge to rsp_valid SHALL be 2*(k+1)+1 cycles for a hit in way k, and 9 cycles for a miss.
REQ-023 In RESP rsp_valid=1, and rsp_* SHALL hold stable until rsp_ready=1; the handshake returns the FSM to IDLE.
REQ-024 A new request SHALL be accepted at the earliest one cycle after the response handshake; requests are never queued.

Reset
REQ-025 While reset_n=0: state=IDLE, way=0, latched VPN=0, req_ready=1 (from the first cycle after release), and rsp_valid, rsp_hit, rsp_way, rsp_ppn, mem_rd_en all 0.
REQ-026 Reset asserted mid-lookup or in RESP SHALL abandon the lookup with no response issued.

Configuration
REQ-027 Macro CUCKOO_LOOKUP_STATS_EN defined: add outputs stat_hits and stat_misses, each 32 bits.
REQ-028 stat_hits and stat_misses SHALL increment on the RESP-entry cycle for a hit or miss respectively, saturate at 0xFFFFFFFF, and reset to 0.
REQ-029 Macro undefined: the ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-030 VPN 0x0_1234_5678_9AB hitting way 0 (vld=1, tag match, ppn=0xAB_CDEF_0123) -> rsp_valid at cycle 3, hit=1, way=0, ppn=0xAB_CDEF_0123, exactly 1 mem_rd_en pulse.
REQ-031 Same VPN, ways 0-1 mismatch and way 2 matches -> rsp_valid at cycle 7, way=2, 3 mem_rd_en pulses, hash_id sequence 0,1,2.
REQ-032 All four ways fail (way 1 has matching tag but vld=0) -> rsp_valid at cycle 9, hit=0, way=3, ppn=0.
REQ-033 Ways 1 and 3 both match -> way=1 is reported and way 3 is never read.
REQ-034 rsp_ready held low 5 cycles -> rsp_* stable and req_ready=0 throughout; reset_n pulsed during PROBE of way 2 -> IDLE next cycle, no rsp_valid, stats unchanged.
